// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter and its round-robin picker.
package mem_bus_pkg;

  localparam int MEM_AW = 16;
  localparam int MEM_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Index width for an n-entry requester vector; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Master-side request/address bundle of the shared memory bus; the tri-state data bus stays a plain net.
interface mem_bus_arbiter_if
  import mem_bus_pkg::*;
#(
  parameter int N  = 2,
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
);

  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N-1:0]    m_rw;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   addr;
  logic            rw;
  logic [DW-1:0]   rdata;
  logic            busy;

  modport master (
    output req, lock, m_addr, m_wdata, m_rw,
    input  gnt, addr, rw, rdata, busy
  );

  modport slave (
    input  req, lock, m_addr, m_wdata, m_rw,
    output gnt, addr, rw, rdata, busy
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after `last`, wrapping at N-1 -> 0.
module rr_pick
  import mem_bus_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] winner,
  output logic [N-1:0]  onehot
);

  logic [IW:0]    start_s;
  logic [2*N-1:0] doubled_s;
  logic [N-1:0]   rot_s;

  // Rotate the request vector so bit 0 is the highest-priority slot, then take the lowest set bit.
  always_comb begin
    start_s   = {1'b0, last} + {{IW{1'b0}}, 1'b1};
    doubled_s = {req, req} >> start_s;
    rot_s     = doubled_s[N-1:0];
    valid     = |req;
    winner    = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot_s[j]) begin
        winner = IW'((int'(start_s) + j) % N);
      end else begin
        winner = winner;
      end
    end
    onehot = valid ? ({{(N-1){1'b0}}, 1'b1} << winner) : {N{1'b0}};
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the shared 8/16-bit memory bus with a dead turnaround cycle on every hand-over.
// Define MEM_BUS_ARB_HOLD_LIMIT_EN to force a yield after MAX_HOLD owned cycles unless the owner holds lock.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int N        = 2,
  parameter int AW       = MEM_AW,
  parameter int DW       = MEM_DW,
  parameter int MAX_HOLD = 16
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus,
  inout wire  [DW-1:0]     data
);

  localparam int IW = idx_width(N);

  arb_state_e    state_r;
  logic [N-1:0]  gnt_r;
  logic [IW-1:0] last_r;
  logic          busy_r;

  logic          pick_valid_s;
  logic [IW-1:0] pick_winner_s;
  logic [N-1:0]  pick_onehot_s;
  logic          owner_req_s;
  logic          others_pending_s;
  logic          preempt_s;

  logic [AW-1:0] addr_s;
  logic [DW-1:0] wdata_s;
  logic          rw_s;

  rr_pick #(.N(N)) u_pick (
    .req    (bus.req),
    .last   (last_r),
    .valid  (pick_valid_s),
    .winner (pick_winner_s),
    .onehot (pick_onehot_s)
  );

  // gnt_r is one-hot, so masking with it selects the owner's bits without an index.
  assign owner_req_s      = |(bus.req & gnt_r);
  assign others_pending_s = |(bus.req & ~gnt_r);

`ifdef MEM_BUS_ARB_HOLD_LIMIT_EN
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HW-1:0] hold_cnt_r;
  logic          hold_expired_s;
  logic          owner_lock_s;

  assign owner_lock_s   = |(bus.lock & gnt_r);
  assign hold_expired_s = (hold_cnt_r == HW'(MAX_HOLD - 1));
  assign preempt_s      = hold_expired_s & ~owner_lock_s & others_pending_s;

  // Owned-cycle counter: zero on the grant cycle, restarts after a full window when nobody is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_r <= '0;
    end else if (state_r != ST_OWNED) begin
      hold_cnt_r <= '0;
    end else if (hold_expired_s) begin
      hold_cnt_r <= '0;
    end else begin
      hold_cnt_r <= hold_cnt_r + HW'(1);
    end
  end
`else
  logic unused_lock_s;

  assign unused_lock_s = |bus.lock;
  assign preempt_s     = 1'b0;
`endif

  // Arbitration FSM; grant, last-owner and busy are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      gnt_r   <= '0;
      last_r  <= IW'(N - 1);
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_TURN: begin
          if (pick_valid_s) begin
            state_r <= ST_OWNED;
            gnt_r   <= pick_onehot_s;
            last_r  <= pick_winner_s;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            gnt_r   <= '0;
            busy_r  <= 1'b0;
          end
        end
        ST_OWNED: begin
          if (!owner_req_s || preempt_s) begin
            gnt_r <= '0;
            if (others_pending_s) begin
              state_r <= ST_TURN;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            state_r <= ST_OWNED;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          gnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // AND-OR bus mux keyed by the one-hot grant; everything reads as zero while nobody owns the bus.
  always_comb begin
    addr_s  = '0;
    wdata_s = '0;
    rw_s    = RW_READ;
    for (int i = 0; i < N; i++) begin
      addr_s  = addr_s  | (bus.m_addr[i*AW +: AW]  & {AW{gnt_r[i]}});
      wdata_s = wdata_s | (bus.m_wdata[i*DW +: DW] & {DW{gnt_r[i]}});
      rw_s    = rw_s    | (bus.m_rw[i] & gnt_r[i]);
    end
  end

  assign data      = (rw_s == RW_WRITE) ? wdata_s : {DW{1'bz}};
  assign bus.rdata = data;
  assign bus.addr  = addr_s;
  assign bus.rw    = rw_s;
  assign bus.gnt   = gnt_r;
  assign bus.busy  = busy_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic against a queue-free owner model.
module tb_mem_bus_arbiter;

  localparam int N        = 2;
  localparam int AW       = 16;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;
`ifdef MEM_BUS_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  wire  [DW-1:0] data;

  mem_bus_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

  mem_bus_arbiter #(.N(N), .AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .data (data)
  );

  // Weak pull so a released bus reads as all ones.
  for (genvar b = 0; b < DW; b++) begin : g_pull
    pullup (data[b]);
  end

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, whether a dead cycle is pending, and for how long the owner has held it.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_held  = 0;
  bit m_turn  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1;
      m_turn  = 1'b0;
      m_last  = N - 1;
      m_held  = 0;
    end else if (m_owner < 0) begin
      m_turn = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && ((bus.req >> ((m_last + k) % N)) & 1) != 0) begin
          m_owner = (m_last + k) % N;
        end
      end
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_held = 1;
      end
    end else begin
      bit mine, others, locked, yield;
      mine   = ((bus.req >> m_owner) & 1) != 0;
      locked = ((bus.lock >> m_owner) & 1) != 0;
      others = (bus.req & ~(2'b01 << m_owner)) != 0;
      yield  = !mine || (HOLD_EN && m_held >= MAX_HOLD && !locked && others);
      if (yield) begin
        m_owner = -1;
        m_turn  = others;
      end else begin
        m_held = (HOLD_EN && m_held >= MAX_HOLD) ? 1 : m_held + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    cycle();
    checks++;
    if (bus.gnt !== 2'b00 || bus.busy !== 1'b0 || bus.addr !== 16'h0000 || bus.rw !== 1'b0 || data !== 8'hFF) begin
      errors++;
      $display("FAIL reset: gnt=%b busy=%b addr=%h rw=%b data=%h want 00 0 0000 0 ff",
               bus.gnt, bus.busy, bus.addr, bus.rw, data);
    end
    rst = 1'b0;
  endtask

  task automatic test_handoff();
    bus.req = 2'b11;
    cycle();
    checks++;
    if (bus.gnt !== 2'b01 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: gnt=%b busy=%b want 01 1", bus.gnt, bus.busy);
    end
    bus.req = 2'b10;
    cycle();
    checks++;
    if (bus.gnt !== 2'b00 || bus.busy !== 1'b1 || data !== 8'hFF) begin
      errors++;
      $display("FAIL turn_cycle: gnt=%b busy=%b data=%h want 00 1 ff", bus.gnt, bus.busy, data);
    end
    cycle();
    checks++;
    if (bus.gnt !== 2'b10) begin
      errors++;
      $display("FAIL second_grant: gnt=%b want 10", bus.gnt);
    end
  endtask

  task automatic test_write_data();
    bus.m_rw    = 2'b10;
    bus.m_wdata = {8'hA5, 8'h3C};
    bus.m_addr  = {16'h1234, 16'hBEEF};
    cycle();
    checks++;
    if (data !== 8'hA5 || bus.rdata !== 8'hA5 || bus.addr !== 16'h1234 || bus.rw !== 1'b1) begin
      errors++;
      $display("FAIL write_m1: data=%h rdata=%h addr=%h rw=%b want a5 a5 1234 1",
               data, bus.rdata, bus.addr, bus.rw);
    end
    bus.req = 2'b01;
    cycle();
    checks++;
    if (bus.gnt !== 2'b00 || data !== 8'hFF || bus.addr !== 16'h0000) begin
      errors++;
      $display("FAIL turn_release: gnt=%b data=%h addr=%h want 00 ff 0000", bus.gnt, data, bus.addr);
    end
    cycle();
    checks++;
    if (bus.gnt !== 2'b01 || bus.rw !== 1'b0 || data !== 8'hFF || bus.addr !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_m0: gnt=%b rw=%b data=%h addr=%h want 01 0 ff beef",
               bus.gnt, bus.rw, data, bus.addr);
    end
  endtask

  task automatic test_glitch();
    bus.req = 2'b00;
    cycle();
    cycle();
    bus.req = 2'b01;
    cycle();
    checks++;
    if (bus.gnt !== 2'b01) begin
      errors++;
      $display("FAIL glitch_grant: gnt=%b want 01", bus.gnt);
    end
    bus.req = 2'b00;
    cycle();
    checks++;
    if (bus.gnt !== 2'b00 || bus.busy !== 1'b0 || bus.addr !== 16'h0000) begin
      errors++;
      $display("FAIL glitch_idle: gnt=%b busy=%b addr=%h want 00 0 0000", bus.gnt, bus.busy, bus.addr);
    end
  endtask

  task automatic test_reset_mid();
    bus.req = 2'b10;
    cycle();
    checks++;
    if (bus.gnt !== 2'b10 || data !== 8'hA5) begin
      errors++;
      $display("FAIL pre_reset_write: gnt=%b data=%h want 10 a5", bus.gnt, data);
    end
    rst = 1'b1;
    cycle();
    checks++;
    if (bus.gnt !== 2'b00 || bus.rw !== 1'b0 || data !== 8'hFF || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: gnt=%b rw=%b data=%h busy=%b want 00 0 ff 0", bus.gnt, bus.rw, data, bus.busy);
    end
    rst = 1'b0;
    bus.req = 2'b11;
    cycle();
    checks++;
    if (bus.gnt !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_order: gnt=%b want 01", bus.gnt);
    end
  endtask

  task automatic test_hold_limit();
    logic [N-1:0] want;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.req  = 2'b11;
    bus.lock = 2'b00;
    for (int p = 0; p < 20; p++) begin
      cycle();
      if (HOLD_EN) begin
        want = ((p % 10) < 4) ? 2'b01 : (((p % 10) == 4 || (p % 10) == 9) ? 2'b00 : 2'b10);
      end else begin
        want = 2'b01;
      end
      checks++;
      if (bus.gnt !== want) begin
        errors++;
        $display("FAIL hold_pattern[%0d]: gnt=%b want %b", p, bus.gnt, want);
      end
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.lock = 2'b01;
    for (int p = 0; p < 12; p++) begin
      cycle();
      checks++;
      if (bus.gnt !== 2'b01) begin
        errors++;
        $display("FAIL lock_hold[%0d]: gnt=%b want 01", p, bus.gnt);
      end
    end
    bus.lock = 2'b00;
    bus.req  = 2'b00;
  endtask

  task automatic test_random();
    logic [N-1:0]  want_gnt;
    logic [AW-1:0] want_addr;
    logic          want_rw;
    logic [DW-1:0] want_data;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) bus.req  = bus.req  ^ (2'b01 << b);
        if ($urandom_range(0, 7) == 0) bus.lock = bus.lock ^ (2'b01 << b);
      end
      bus.m_rw    = N'($urandom);
      bus.m_addr  = (N*AW)'({$urandom, $urandom});
      bus.m_wdata = (N*DW)'($urandom);
      rst = ($urandom_range(0, 39) == 0);
      cycle();
      want_gnt  = (m_owner >= 0) ? (2'b01 << m_owner) : 2'b00;
      want_addr = (m_owner >= 0) ? AW'(bus.m_addr >> (m_owner * AW)) : '0;
      want_rw   = (m_owner >= 0) ? (((bus.m_rw >> m_owner) & 1) != 0) : 1'b0;
      want_data = want_rw ? DW'(bus.m_wdata >> (m_owner * DW)) : 8'hFF;
      checks++;
      if (bus.gnt !== want_gnt || bus.busy !== (m_owner >= 0 || m_turn)) begin
        errors++;
        $display("FAIL rand_gnt[%0d]: gnt=%b busy=%b want %b %b", c, bus.gnt, bus.busy,
                 want_gnt, (m_owner >= 0 || m_turn));
      end
      checks++;
      if (bus.addr !== want_addr || bus.rw !== want_rw || data !== want_data || bus.rdata !== want_data) begin
        errors++;
        $display("FAIL rand_bus[%0d]: addr=%h rw=%b data=%h rdata=%h want %h %b %h %h", c,
                 bus.addr, bus.rw, data, bus.rdata, want_addr, want_rw, want_data, want_data);
      end
    end
    bus.req = '0;
    rst = 1'b0;
  endtask

  initial begin
    clk         = 1'b0;
    rst         = 1'b1;
    bus.req     = '0;
    bus.lock    = '0;
    bus.m_rw    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    test_reset();
    test_handoff();
    test_write_data();
    test_glitch();
    test_reset_mid();
    test_hold_limit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
